// File: rtl/clause_loader.sv
// Streams clause coefficients in one beat at a time, packs each clause's vector and
// strobes its 1-based clause index to the register bank for exactly one cycle.
module clause_loader #(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT = 2,
  parameter int unsigned NUMBER_OF_INTEGER_VARIABLES              = 2,
  parameter int unsigned NUMBER_OF_CLAUSES                        = 3,
  parameter int unsigned MAX_BIT_WIDTH_OF_CLAUSES_INDEX           = 2
) (
  input  logic                                                in_clk,
  input  logic                                                in_reset,
  input  logic                                                in_start,
  input  logic                                                in_coeff_valid,
  input  logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] in_coeff,
  output logic                                                out_coeff_ready,
  output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT*(NUMBER_OF_INTEGER_VARIABLES+1)-1:0]
                                                              out_clause_coefficients,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]           out_clause_index,
  output logic                                                out_busy,
  output logic                                                out_done
);

  localparam int unsigned W     = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
  localparam int unsigned N     = NUMBER_OF_INTEGER_VARIABLES;
  localparam int unsigned VecW  = W * (N + 1);
  localparam int unsigned BeatW = (N > 0) ? $clog2(N + 1) : 1;
  localparam int unsigned IdxW  = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;

  localparam logic [BeatW-1:0] LastBeat   = BeatW'(N);
  localparam logic [IdxW-1:0]  FirstClause = IdxW'(1);
  localparam logic [IdxW-1:0]  LastClause  = IdxW'(NUMBER_OF_CLAUSES);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } state_e;

  state_e           r_state;
  logic [BeatW-1:0] r_beat_cnt;
  logic [IdxW-1:0]  r_clause_cnt;
  logic [VecW-1:0]  r_buf;
  logic [VecW-1:0]  r_coeffs;
  logic [IdxW-1:0]  r_index;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_next;
  logic [BeatW-1:0] w_beat_next;
  logic [IdxW-1:0]  w_clause_next;
  logic [VecW-1:0]  w_buf_next;
  logic [VecW-1:0]  w_coeffs_next;
  logic [IdxW-1:0]  w_index_next;
  logic             w_ready_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_accept;

  // r_ready is only ever high in COLLECT, but the state term keeps acceptance explicit.
  assign w_accept = in_coeff_valid && r_ready && (r_state == StCollect);

  always_comb begin
    w_state_next  = r_state;
    w_beat_next   = r_beat_cnt;
    w_clause_next = r_clause_cnt;
    w_buf_next    = r_buf;
    w_coeffs_next = r_coeffs;
    w_index_next  = '0;

    unique case (r_state)
      StIdle: begin
        if (in_start) begin
          w_state_next  = StCollect;
          w_clause_next = FirstClause;
          w_beat_next   = '0;
        end
      end
      StCollect: begin
        if (w_accept) begin
          w_buf_next[int'(r_beat_cnt) * W +: W] = in_coeff;
          if (r_beat_cnt == LastBeat) begin
            // Issue the merged vector together with its index on the same edge.
            w_state_next  = StWrite;
            w_coeffs_next = w_buf_next;
            w_index_next  = r_clause_cnt;
          end else begin
            w_beat_next = r_beat_cnt + BeatW'(1);
          end
        end
      end
      StWrite: begin
        w_beat_next = '0;
        if (r_clause_cnt < LastClause) begin
          w_clause_next = r_clause_cnt + IdxW'(1);
          w_state_next  = StCollect;
        end else begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    w_ready_next = (w_state_next == StCollect);
    w_busy_next  = (w_state_next == StCollect) || (w_state_next == StWrite);
    w_done_next  = (w_state_next == StDone);
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      r_state      <= StIdle;
      r_beat_cnt   <= '0;
      r_clause_cnt <= '0;
      r_buf        <= '0;
      r_coeffs     <= '0;
      r_index      <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_beat_cnt   <= w_beat_next;
      r_clause_cnt <= w_clause_next;
      r_buf        <= w_buf_next;
      r_coeffs     <= w_coeffs_next;
      r_index      <= w_index_next;
      r_ready      <= w_ready_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
    end
  end

  assign out_coeff_ready         = r_ready;
  assign out_clause_coefficients = r_coeffs;
  assign out_clause_index        = r_index;
  assign out_busy                = r_busy;
  assign out_done                = r_done;

endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader: a 3-clause instance feeding a modelled register
// bank, plus a 1-clause instance for the single-clause case.
module tb_clause_loader;

  logic       clk;
  logic       rst, start, valid;
  logic [1:0] coeff;
  logic       ready, busy, done;
  logic [5:0] vec;
  logic [1:0] idx;

  logic       s_rst, s_start, s_valid;
  logic [1:0] s_coeff;
  logic       s_ready, s_busy, s_done;
  logic [5:0] s_vec;
  logic [1:0] s_idx;

  int n_assert = 0;
  int n_fail   = 0;

  clause_loader #(
    .MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT(2),
    .NUMBER_OF_INTEGER_VARIABLES(2),
    .NUMBER_OF_CLAUSES(3),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX(2)
  ) dut (
    .in_clk(clk),
    .in_reset(rst),
    .in_start(start),
    .in_coeff_valid(valid),
    .in_coeff(coeff),
    .out_coeff_ready(ready),
    .out_clause_coefficients(vec),
    .out_clause_index(idx),
    .out_busy(busy),
    .out_done(done)
  );

  clause_loader #(
    .MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT(2),
    .NUMBER_OF_INTEGER_VARIABLES(2),
    .NUMBER_OF_CLAUSES(1),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX(2)
  ) dut_single (
    .in_clk(clk),
    .in_reset(s_rst),
    .in_start(s_start),
    .in_coeff_valid(s_valid),
    .in_coeff(s_coeff),
    .out_coeff_ready(s_ready),
    .out_clause_coefficients(s_vec),
    .out_clause_index(s_idx),
    .out_busy(s_busy),
    .out_done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe log and done-pulse count, sampled on the falling edge.
  int         rec_n  = 0;
  int         done_n = 0;
  logic [1:0] rec_idx [64];
  logic [5:0] rec_vec [64];

  always @(negedge clk) begin
    if (idx != 2'd0) begin
      if (rec_n < 64) begin
        rec_idx[rec_n] = idx;
        rec_vec[rec_n] = vec;
      end
      rec_n++;
    end
    if (done) done_n++;
  end

  // Register bank model: register k captures when the index equals k.
  logic [5:0] bank [1:3];
  always @(posedge clk) begin
    for (int k = 1; k <= 3; k++) begin
      if (idx == 2'(k)) bank[k] <= vec;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one beat after 'gap' idle cycles and waits (bounded) until it is taken.
  task automatic send_beat(input logic [1:0] v, input int gap);
    bit ok;
    if (gap > 0) begin
      valid = 1'b0;
      repeat (gap) tick();
    end
    valid = 1'b1;
    coeff = v;
    ok    = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (ready) ok = 1'b1;
      tick();
    end
    check("beat_accepted", 32'(ok), 32'd1);
  endtask

  task automatic check_run(input string tag, input int base, input int dbase);
    logic [1:0] e_idx [3];
    logic [5:0] e_vec [3];
    e_idx = '{2'd1, 2'd2, 2'd3};
    e_vec = '{6'h39, 6'h2C, 6'h1A};
    check({tag, "_strobe_count"}, 32'(rec_n - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_strobe_idx"}, 32'(rec_idx[base + i]), 32'(e_idx[i]));
      check({tag, "_strobe_vec"}, 32'(rec_vec[base + i]), 32'(e_vec[i]));
    end
    check({tag, "_done_pulses"}, 32'(done_n - dbase), 32'd1);
  endtask

  initial begin
    int base;
    int dbase;
    bit seen;

    rst = 1'b1; start = 1'b0; valid = 1'b0; coeff = 2'd0;
    s_rst = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_coeff = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    s_rst = 1'b0;
    tick();
    check("reset_idx", 32'(idx), 32'd0);
    check("reset_vec", 32'(vec), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Reset mid-COLLECT after one beat.
    base = rec_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(ready), 32'd1);
    send_beat(2'd3, 0);
    valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midreset_idx", 32'(idx), 32'd0);
    check("midreset_vec", 32'(vec), 32'd0);
    check("midreset_ready", 32'(ready), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_no_strobe", 32'(rec_n - base), 32'd0);

    // Valid high in IDLE must be ignored.
    valid = 1'b1;
    coeff = 2'd2;
    repeat (3) tick();
    check("idle_valid_ready", 32'(ready), 32'd0);
    check("idle_valid_busy", 32'(busy), 32'd0);
    valid = 1'b0;

    // Back-to-back run with spurious start pulses and valid held through WRITE.
    base  = rec_n;
    dbase = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(2'd1, 0);
    start = 1'b1;
    send_beat(2'd2, 0);
    start = 1'b0;
    send_beat(2'd3, 0);
    check("write1_idx", 32'(idx), 32'd1);
    check("write1_vec", 32'(vec), 32'h39);
    check("write1_ready", 32'(ready), 32'd0);
    check("write1_busy", 32'(busy), 32'd1);
    start = 1'b1;
    coeff = 2'd0;
    tick();
    start = 1'b0;
    check("after_write1_idx", 32'(idx), 32'd0);
    check("after_write1_ready", 32'(ready), 32'd1);
    send_beat(2'd0, 0);
    send_beat(2'd3, 0);
    send_beat(2'd2, 0);
    check("write2_idx", 32'(idx), 32'd2);
    check("write2_vec", 32'(vec), 32'h2C);
    send_beat(2'd2, 0);
    send_beat(2'd2, 0);
    send_beat(2'd1, 0);
    valid = 1'b0;
    check("write3_idx", 32'(idx), 32'd3);
    check("write3_vec", 32'(vec), 32'h1A);
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_idx", 32'(idx), 32'd0);
    tick();
    check("done_cleared", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hold_vec", 32'(vec), 32'h1A);
    check_run("b2b", base, dbase);
    repeat (3) tick();
    check("bank1", 32'(bank[1]), 32'h39);
    check("bank2", 32'(bank[2]), 32'h2C);
    check("bank3", 32'(bank[3]), 32'h1A);

    // Same clauses with random idle gaps.
    base  = rec_n;
    dbase = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(2'd1, int'($urandom_range(0, 3)));
    send_beat(2'd2, int'($urandom_range(0, 3)));
    send_beat(2'd3, int'($urandom_range(0, 3)));
    send_beat(2'd0, int'($urandom_range(0, 3)));
    send_beat(2'd3, int'($urandom_range(0, 3)));
    send_beat(2'd2, int'($urandom_range(0, 3)));
    send_beat(2'd2, int'($urandom_range(0, 3)));
    send_beat(2'd2, int'($urandom_range(0, 3)));
    send_beat(2'd1, int'($urandom_range(0, 3)));
    valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("gaps_done_seen", 32'(seen), 32'd1);
    repeat (2) tick();
    check_run("gaps", base, dbase);
    check("gaps_bank1", 32'(bank[1]), 32'h39);
    check("gaps_bank2", 32'(bank[2]), 32'h2C);
    check("gaps_bank3", 32'(bank[3]), 32'h1A);

    // Single-clause instance.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_valid = 1'b1;
    s_coeff = 2'd1;
    tick();
    s_coeff = 2'd2;
    tick();
    s_coeff = 2'd3;
    tick();
    s_valid = 1'b0;
    check("single_idx", 32'(s_idx), 32'd1);
    check("single_vec", 32'(s_vec), 32'h39);
    check("single_ready", 32'(s_ready), 32'd0);
    tick();
    check("single_idx_cleared", 32'(s_idx), 32'd0);
    check("single_done", 32'(s_done), 32'd1);
    check("single_busy_fall", 32'(s_busy), 32'd0);
    tick();
    check("single_done_cleared", 32'(s_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
